condlogic: RTL and testbench
============================

# condlogic

Conditional-execution unit for the multicycle ARM core. It sits directly downstream of the main control FSM, inside the controller. It holds the architectural NZCV flags and evaluates each instruction's condition field. It gates the FSM's raw write requests (PCS/NextPC, RegW, MemW, FlagW) into the committed write enables that drive the PC register, register file and data memory.

## Interface
Parameters: none. Widths are fixed by the ISA.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; clears all state on the rising clk edge where it is high
- Cond  in  4  instruction condition field, Instr[31:28]
- ALUFlags  in  4  ALU result flags {N,Z,C,V} from the current ALU operation
- FlagW  in  2  flag-write request from the ALU decoder; [1] requests an N,Z write, [0] requests a C,V write
- PCS  in  1  PC-source request: branch, or a data-processing write to R15
- NextPC  in  1  unconditional PC update request (FETCH state)
- RegW  in  1  raw register-write request from the FSM
- MemW  in  1  raw memory-write request from the FSM
- PCWrite  out  1  committed PC write enable
- RegWrite  out  1  committed register-file write enable
- MemWrite  out  1  committed data-memory write enable
- Flags  out  4  current architectural flags {N,Z,C,V}, for observation and debug

## Operation
- State consists of Flags[3:2] (N,Z), Flags[1:0] (C,V) and CondExDelayed (1 bit).
- CondEx is combinational, computed from Cond and the registered Flags:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (never executes)
- FlagWrite[1:0] = FlagW & {CondEx, CondEx}. A failed condition never updates flags.
- Flags[3:2] <= ALUFlags[3:2] when FlagWrite[1]. Flags[1:0] <= ALUFlags[1:0] when FlagWrite[0]. The two halves are independent, so a partial update is legal.
- CondExDelayed <= CondEx on every cycle, with no enable.
- PCWrite = (PCS & CondExDelayed) | NextPC
- RegWrite = RegW & CondExDelayed
- MemWrite = MemW & CondExDelayed
- No internal FSM. Sequencing comes entirely from the upstream control FSM.

## Timing
- Reset values: Flags = 4'b0000, CondExDelayed = 0. Consequently, immediately after reset PCWrite = NextPC, RegWrite = 0 and MemWrite = 0.
- Outputs are combinational from inputs and registers. They are not directly masked by reset; they reflect the cleared registers from the cycle after the reset edge.
- Flag update latency: ALUFlags sampled at the end of the EXECUTE cycle are visible on Flags and CondEx in the following cycle (ALUWB or FETCH).
- Condition commit latency: CondEx evaluated in cycle t gates the write enables in cycle t+1. This matches the FSM pairs EXECUTE→ALUWB, MEMADR→MEMWR/MEMRD, MEMRD→MEMWB (CondEx stable across MEMADR/MEMRD), and DECODE→BRANCH.
- CondEx in the flag-setting cycle uses the old flags. A flag-setting instruction whose condition depends on flags it also writes behaves per ARM semantics.
- NextPC overrides the condition. PCWrite = 1 whenever NextPC = 1, regardless of CondExDelayed.
- Reset asserted mid-instruction: the next edge clears Flags and CondExDelayed, so any pending RegWrite/MemWrite is suppressed from that cycle on.
- Simultaneous FlagW and reset: reset wins.

## Structure
- Shared package `arm_pkg`:
  - condition-code localparams (COND_EQ … COND_NV)
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
- Sub-module `condcheck` holds the purely combinational 16-way condition decoder (Cond, Flags → CondEx).
- `condlogic` holds the two flag flops, the CondEx delay flop and the output gating.

## Test plan
- Reset with all inputs at 0, deassert. Then Flags = 0000, RegWrite = 0. Cond = 1110, RegW = 1 for two cycles → RegWrite = 1 in the second cycle only.
- Cond = 1110, FlagW = 11, ALUFlags = 0100 for one cycle → next cycle Flags = 0100. Then Cond = 0000 (EQ) gives CondEx = 1; Cond = 0001 (NE) gives RegW gated off, RegWrite = 0.
- Partial update: Flags = 1111, then FlagW = 10, ALUFlags = 0000 → Flags = 0011.
- Failed condition: Flags = 0000, Cond = 0000, FlagW = 11, ALUFlags = 1111 → Flags stay 0000. Following MemW = 1 → MemWrite = 0.
- Branch: Flags = 1001 (N=V). Cond = 1010 (GE) in DECODE, then PCS = 1 next cycle → PCWrite = 1. Repeat with Cond = 1011 (LT) → PCWrite = 0. NextPC = 1 with Cond = 1111 → PCWrite = 1.
- Sweep all 16 Cond values × all 16 Flags values against the reference equations; RegWrite must equal the expected CondEx one cycle later.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM controller definitions: condition-code encodings and NZCV flag bit positions.
// Pure constants; no latency or flow control involved.
package arm_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/condcheck.sv
// 16-way ARM condition decoder (Cond, NZCV -> CondEx); purely combinational, zero latency.
// No flow control: output follows inputs in the same cycle.
module condcheck
  import arm_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v, ge;

  assign n  = Flags[FLAG_N];
  assign z  = Flags[FLAG_Z];
  assign c  = Flags[FLAG_C];
  assign v  = Flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~z & ge;
      COND_LE: CondEx = z | ~ge;
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/condlogic.sv
// Conditional-execution unit: holds NZCV, gates FSM write requests; flags visible 1 cycle after write,
// condition gates write enables 1 cycle after evaluation. No backpressure; sequencing is upstream.
module condlogic
  import arm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags
);

  logic       CondEx;
  logic       CondExDelayed;
  logic [1:0] FlagWrite;

  // Evaluated against the registered flags, so a flag-setting instruction sees the old flags.
  condcheck u_condcheck (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (CondEx)
  );

  assign FlagWrite = FlagW & {2{CondEx}};

  always_ff @(posedge clk) begin
    if (reset) begin
      Flags         <= 4'b0000;
      CondExDelayed <= 1'b0;
    end else begin
      if (FlagWrite[1]) Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (FlagWrite[0]) Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      CondExDelayed <= CondEx;
    end
  end

  // NextPC is the fetch-time PC increment and must never be suppressed by a condition.
  assign PCWrite  = (PCS & CondExDelayed) | NextPC;
  assign RegWrite = RegW & CondExDelayed;
  assign MemWrite = MemW & CondExDelayed;

endmodule

// File: tb/tb_condlogic.sv
// Bench for condlogic: a reference model predicts every cycle's outputs into a scoreboard queue,
// plus directed checks against constants for the key sequences.
module tb_condlogic;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;

  int errors = 0;
  int checks = 0;

  logic [6:0] sb_q[$];

  logic [3:0] m_flags;
  logic       m_cexd;
  logic       m_valid = 1'b0;

  condlogic dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .NextPC   (NextPC),
    .RegW     (RegW),
    .MemW     (MemW),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model advances on the same edge as the DUT, from the bench-driven inputs.
  always @(posedge clk) begin
    if (reset) begin
      m_flags <= 4'b0000;
      m_cexd  <= 1'b0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      if (FlagW[1] && ref_cond(Cond, m_flags)) m_flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0] && ref_cond(Cond, m_flags)) m_flags[1:0] <= ALUFlags[1:0];
      m_cexd <= ref_cond(Cond, m_flags);
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, predict outputs, then compare.
  task automatic step(input logic rst, input logic [3:0] c, input logic [1:0] fw,
                      input logic [3:0] af, input logic pcs_i, input logic npc_i,
                      input logic regw_i, input logic memw_i);
    logic [6:0] exp_v;
    @(negedge clk);
    reset = rst; Cond = c; FlagW = fw; ALUFlags = af;
    PCS = pcs_i; NextPC = npc_i; RegW = regw_i; MemW = memw_i;
    if (m_valid) begin
      sb_q.push_back({(pcs_i & m_cexd) | npc_i, regw_i & m_cexd, memw_i & m_cexd, m_flags});
      #1;
      exp_v = sb_q.pop_front();
      check("sb", {1'b0, PCWrite, RegWrite, MemWrite, Flags}, {1'b0, exp_v});
    end else begin
      #1;
    end
  endtask

  task automatic idle(input logic [3:0] c);
    step(1'b0, c, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_flags(input logic [3:0] f);
    step(1'b0, 4'hE, 2'b11, f, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; Cond = '0; ALUFlags = '0; FlagW = '0;
    PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;

    step(1'b1, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_flags", {4'h0, Flags}, 8'h00);
    check("rst_regwrite", {7'h0, RegWrite}, 8'h00);

    step(1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("al_first", {7'h0, RegWrite}, 8'h00);
    step(1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("al_second", {7'h0, RegWrite}, 8'h01);

    set_flags(4'b0100);
    idle(4'h0);
    check("flags_z", {4'h0, Flags}, 8'h04);
    step(1'b0, 4'h1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("eq_pass", {7'h0, RegWrite}, 8'h01);
    step(1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ne_fail", {7'h0, RegWrite}, 8'h00);

    set_flags(4'b1111);
    step(1'b0, 4'hE, 2'b10, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4'hE);
    check("partial_nz", {4'h0, Flags}, 8'h03);

    set_flags(4'b0000);
    step(1'b0, 4'h0, 2'b11, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("failed_noflag", {4'h0, Flags}, 8'h00);
    check("failed_memw", {7'h0, MemWrite}, 8'h00);

    set_flags(4'b1001);
    idle(4'hA);
    step(1'b0, 4'hA, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ge_branch", {7'h0, PCWrite}, 8'h01);
    idle(4'hB);
    step(1'b0, 4'hB, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lt_branch", {7'h0, PCWrite}, 8'h00);
    step(1'b0, 4'hF, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("nextpc_nv", {7'h0, PCWrite}, 8'h01);

    // Mid-instruction reset, and reset racing a flag write.
    idle(4'hE);
    step(1'b1, 4'hE, 2'b11, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
    check("pre_rst_regw", {7'h0, RegWrite}, 8'h01);
    step(1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("post_rst_regw", {6'h0, RegWrite, MemWrite}, 8'h00);
    check("rst_beats_flagw", {4'h0, Flags}, 8'h00);

    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        set_flags(4'(f));
        idle(4'(c));
        step(1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        check($sformatf("sweep c%0d f%0d", c, f), {7'h0, RegWrite},
              {7'h0, ref_cond(4'(c), 4'(f))});
      end
    end

    idle(4'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
